// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2^m) constants, FSM state type and digit-count helper
package gf_pkg;

    localparam int         GF8_M        = 8;
    localparam logic [7:0] GF8_AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    function automatic int gf_digit_count(input int m, input int d);
        return m / d;
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// rtl/gf_xtime.sv - combinational multiply-by-x in GF(2^M) modulo x^M + POLY
module gf_xtime #(
    parameter int          M    = 8,
    parameter logic [M-1:0] POLY = 8'h1B
) (
    input  logic [M-1:0] v_i,
    output logic [M-1:0] v_o
);

    assign v_o = {v_i[M-2:0], 1'b0} ^ (POLY & {M{v_i[M-1]}});

endmodule

// File: rtl/gf_mul_serial.sv
// rtl/gf_mul_serial.sv - digit-serial GF(2^M) multiplier, D bits of b per cycle; GF_MUL_SERIAL_ACC_EN adds acc_i
module gf_mul_serial
    import gf_pkg::*;
#(
    parameter int           M    = GF8_M,
    parameter logic [M-1:0] POLY = M'(GF8_AES_POLY),
    parameter int           D    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
`ifdef GF_MUL_SERIAL_ACC_EN
    input  logic         acc_i,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] p_o
);

    localparam int             NDIG     = gf_digit_count(M, D);
    localparam int             CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(NDIG - 1);

    gf_state_e     state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [M-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  acc_next;
    logic [M-1:0]  result;
    logic          accept;

    // One Horner step per stage, MSB of the current digit first.
    for (genvar k = 0; k < D; k++) begin : g_stage
        logic [M-1:0] stage_in;
        logic [M-1:0] stage_x;
        logic [M-1:0] stage_out;
        if (k == 0) begin : g_first
            assign stage_in = acc_q;
        end else begin : g_next
            assign stage_in = g_stage[k-1].stage_out;
        end
        gf_xtime #(.M(M), .POLY(POLY)) u_xtime (
            .v_i (stage_in),
            .v_o (stage_x)
        );
        assign stage_out = stage_x ^ (a_q & {M{b_q[M-1-k]}});
    end

    assign acc_next = g_stage[D-1].stage_out;

`ifdef GF_MUL_SERIAL_ACC_EN
    logic acc_en_q, acc_en_d;
    assign result = acc_en_q ? (acc_next ^ p_q) : acc_next;
`else
    assign result = acc_next;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign p_o       = p_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
`ifdef GF_MUL_SERIAL_ACC_EN
        acc_en_d = acc_en_q;
`endif
        case (state_q)
            BUSY: begin
                acc_d = acc_next;
                b_d   = b_q << D;
                if (cnt_q == '0) begin
                    p_d     = result;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            a_d     = a_i;
            b_d     = b_i;
            acc_d   = '0;
            cnt_d   = CNT_LAST;
            state_d = BUSY;
`ifdef GF_MUL_SERIAL_ACC_EN
            acc_en_d = acc_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
`ifdef GF_MUL_SERIAL_ACC_EN
            acc_en_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
`ifdef GF_MUL_SERIAL_ACC_EN
            acc_en_q <= acc_en_d;
`endif
        end
    end

endmodule

// File: tb/tb_gf_mul_serial.sv
// tb/tb_gf_mul_serial.sv - randomized self-checking bench for gf_mul_serial (D=1, 4, 8 and M=4)
module tb_gf_mul_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, acc_i;
    logic [7:0] a_i, b_i, p_o;

    logic       w_valid, w_out_ready, rdy4, rdy8, ov4, ov8;
    logic [7:0] w_a, w_b, p4, p8;

    logic       m_valid, m_ready, m_ov, m_out_ready;
    logic [3:0] m_a, m_b, m_p;

    int n_tests = 0;
    int n_fail  = 0;

    gf_mul_serial #(.M(8), .POLY(8'h1B), .D(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a_i), .b_i(b_i),
`ifdef GF_MUL_SERIAL_ACC_EN
        .acc_i(acc_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .p_o(p_o)
    );

    gf_mul_serial #(.M(8), .POLY(8'h1B), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(rdy4),
        .a_i(w_a), .b_i(w_b),
`ifdef GF_MUL_SERIAL_ACC_EN
        .acc_i(1'b0),
`endif
        .out_valid(ov4), .out_ready(w_out_ready), .p_o(p4)
    );

    gf_mul_serial #(.M(8), .POLY(8'h1B), .D(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(rdy8),
        .a_i(w_a), .b_i(w_b),
`ifdef GF_MUL_SERIAL_ACC_EN
        .acc_i(1'b0),
`endif
        .out_valid(ov8), .out_ready(w_out_ready), .p_o(p8)
    );

    gf_mul_serial #(.M(4), .POLY(4'h3), .D(2)) u_m4 (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_ready),
        .a_i(m_a), .b_i(m_b),
`ifdef GF_MUL_SERIAL_ACC_EN
        .acc_i(1'b0),
`endif
        .out_valid(m_ov), .out_ready(m_out_ready), .p_o(m_p)
    );

    // Schoolbook LSB-first shift-and-add with reduction after every shift.
    function automatic int ref_mul(input int a, input int b, input int m, input int poly);
        int r;
        int aa;
        r  = 0;
        aa = a;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ aa;
            aa = aa << 1;
            if (((aa >> m) & 1) != 0) aa = aa ^ (1 << m) ^ poly;
        end
        return r;
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                         output logic [7:0] p, output int lat);
        int n;
        @(negedge clk);
        a_i = a; b_i = b; acc_i = acc; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        p = p_o;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_wide(input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r4, output logic [7:0] r8,
                            output int l4, output int l8);
        @(negedge clk);
        w_a = a; w_b = b; w_valid = 1'b1; w_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        l4 = 99; l8 = 99; r4 = 8'hxx; r8 = 8'hxx;
        for (int n = 0; n < 12; n++) begin
            if (ov4 && l4 == 99) begin l4 = n; r4 = p4; end
            if (ov8 && l8 == 99) begin l8 = n; r8 = p8; end
            @(negedge clk);
        end
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; acc_i = 1'b0; a_i = '0; b_i = '0;
        w_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0;
        m_valid = 1'b0; m_out_ready = 1'b0; m_a = '0; m_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (p_o !== 8'h00) begin n_fail++; $display("FAIL reset_p_o: got %h expected 00", p_o); end
        rst = 1'b0;
    endtask

    task automatic test_known_d1();
        logic [7:0] va [4] = '{8'h57, 8'h57, 8'h02, 8'hFF};
        logic [7:0] vb [4] = '{8'h83, 8'h13, 8'h80, 8'h00};
        logic [7:0] ve [4] = '{8'hC1, 8'hFE, 8'h1B, 8'h00};
        logic [7:0] p;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, p, lat);
            n_tests++; if (p !== ve[i]) begin n_fail++; $display("FAIL d1_product %h*%h: got %h expected %h", va[i], vb[i], p, ve[i]); end
            n_tests++; if (lat != 8) begin n_fail++; $display("FAIL d1_latency %h*%h: got %0d expected 8", va[i], vb[i], lat); end
        end
    endtask

    task automatic test_random_d1();
        logic [7:0] a, b, p;
        int lat;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            do_op(a, b, 1'b0, p, lat);
            n_tests++; if (p !== 8'(ref_mul(a, b, 8, 8'h1B))) begin n_fail++; $display("FAIL d1_random %h*%h: got %h expected %h", a, b, p, 8'(ref_mul(a, b, 8, 8'h1B))); end
        end
    endtask

    task automatic test_digit_sizes();
        logic [7:0] va [4] = '{8'h57, 8'h57, 8'h02, 8'hFF};
        logic [7:0] vb [4] = '{8'h83, 8'h13, 8'h80, 8'h00};
        logic [7:0] ve [4] = '{8'hC1, 8'hFE, 8'h1B, 8'h00};
        logic [7:0] a, b, e, r4, r8;
        int l4, l8;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                a = va[i]; b = vb[i]; e = ve[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom); e = 8'(ref_mul(a, b, 8, 8'h1B));
            end
            run_wide(a, b, r4, r8, l4, l8);
            n_tests++; if (r4 !== e) begin n_fail++; $display("FAIL d4_product %h*%h: got %h expected %h", a, b, r4, e); end
            n_tests++; if (r8 !== e) begin n_fail++; $display("FAIL d8_product %h*%h: got %h expected %h", a, b, r8, e); end
            n_tests++; if (l4 != 2) begin n_fail++; $display("FAIL d4_latency: got %0d expected 2", l4); end
            n_tests++; if (l8 != 1) begin n_fail++; $display("FAIL d8_latency: got %0d expected 1", l8); end
        end
    endtask

    task automatic test_m4();
        logic [3:0] a, b, e, p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 4'h9; b = 4'h3; e = 4'h8;
            end else begin
                a = 4'($urandom); b = 4'($urandom); e = 4'(ref_mul(a, b, 4, 4'h3));
            end
            @(negedge clk);
            m_a = a; m_b = b; m_valid = 1'b1; m_out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            m_valid = 1'b0;
            lat = 0;
            while (!m_ov && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            p = m_p;
            n_tests++; if (p !== e) begin n_fail++; $display("FAIL m4_product %h*%h: got %h expected %h", a, b, p, e); end
            n_tests++; if (lat != 2) begin n_fail++; $display("FAIL m4_latency: got %0d expected 2", lat); end
            m_out_ready = 1'b1;
            @(negedge clk);
            m_out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a_i = 8'h57; b_i = 8'h83; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (p_o !== 8'hC1) begin n_fail++; $display("FAIL bp_hold_p_o cycle %0d: got %h expected c1", i, p_o); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready); end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle %0d: got %b expected 1", i, out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; a_i = 8'h57; b_i = 8'h13;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accepted_busy: got %b expected 0", out_valid); end
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_tests++; if (lat != 8) begin n_fail++; $display("FAIL bp_next_latency: got %0d expected 8", lat); end
        n_tests++; if (p_o !== 8'hFE) begin n_fail++; $display("FAIL bp_next_product: got %h expected fe", p_o); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] p;
        int lat;
        @(negedge clk);
        a_i = 8'h57; b_i = 8'h13; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (p_o !== 8'h00) begin n_fail++; $display("FAIL rst_busy_p_o: got %h expected 00", p_o); end
        repeat (10) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_discarded: got %b expected 0", out_valid); end
        do_op(8'h57, 8'h83, 1'b0, p, lat);
        n_tests++; if (p !== 8'hC1) begin n_fail++; $display("FAIL rst_busy_after: got %h expected c1", p); end
        n_tests++; if (lat != 8) begin n_fail++; $display("FAIL rst_busy_after_latency: got %0d expected 8", lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        logic [7:0] e;
        int last, nres;
        last = -1; nres = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; acc_i = 1'b0;
        for (int cyc = 0; cyc < 75; cyc++) begin
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_tests++; if (p_o !== e) begin n_fail++; $display("FAIL b2b_product #%0d: got %h expected %h", nres, p_o, e); end
                if (last >= 0) begin
                    n_tests++; if (cyc - last != 9) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 9", cyc - last); end
                end
                last = cyc;
                nres++;
            end
            if (cyc == 60) in_valid = 1'b0;
            a_i = 8'($urandom); b_i = 8'($urandom);
            #1;
            if (in_valid && in_ready) exp_q.push_back(8'(ref_mul(a_i, b_i, 8, 8'h1B)));
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drained: got %0d pending expected 0", exp_q.size()); end
        n_tests++; if (nres < 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected at least 6", nres); end
    endtask

`ifdef GF_MUL_SERIAL_ACC_EN
    task automatic test_accumulate();
        logic [7:0] p, prev, a, b, e;
        int lat;
        do_op(8'h57, 8'h83, 1'b0, p, lat);
        n_tests++; if (p !== 8'hC1) begin n_fail++; $display("FAIL acc_plain: got %h expected c1", p); end
        do_op(8'h02, 8'h80, 1'b1, p, lat);
        n_tests++; if (p !== 8'hDA) begin n_fail++; $display("FAIL acc_xor: got %h expected da", p); end
        prev = p;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            e = 8'(ref_mul(a, b, 8, 8'h1B)) ^ prev;
            do_op(a, b, 1'b1, p, lat);
            n_tests++; if (p !== e) begin n_fail++; $display("FAIL acc_random %h*%h: got %h expected %h", a, b, p, e); end
            prev = e;
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_d1();
        test_random_d1();
        test_digit_sizes();
        test_m4();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
`ifdef GF_MUL_SERIAL_ACC_EN
        test_accumulate();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
